// File: rtl/param_pipe_barrel_shifter_pkg.sv
// rtl/param_pipe_barrel_shifter_pkg.sv - shift mode encoding and the per-level shift function
// Covers data widths up to MAX_W; wider operands need MAX_W raised.
package param_pipe_barrel_shifter_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROL = 2'b11
    } shift_mode_e;

    localparam int MAX_W = 256;
    localparam int IDX_W = $clog2(MAX_W);

    // Shift the low w bits of d by 2**k; bits at or above w are returned as 0.
    function automatic logic [MAX_W-1:0] level_shift(
        input logic [MAX_W-1:0] d,
        input shift_mode_e      mode,
        input logic             fill,
        input int               k,
        input int               w
    );
        logic [MAX_W-1:0] r;
        logic [IDX_W-1:0] idx;
        logic             in_range;
        int               s;
        int               src;
        r = '0;
        s = 1 << k;
        for (int i = 0; i < MAX_W; i++) begin
            src      = 0;
            in_range = 1'b0;
            case (mode)
                SLL: begin
                    src      = i - s;
                    in_range = (i >= s);
                end
                SRL, SRA: begin
                    src      = i + s;
                    in_range = (i + s < w);
                end
                default: begin
                    src      = (i >= s) ? (i - s) : (i - s + w);
                    in_range = 1'b1;
                end
            endcase
            idx = IDX_W'(src);
            if (i < w) begin
                r[i] = in_range ? d[idx] : ((mode == SRA) ? fill : 1'b0);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/param_pipe_barrel_shifter_shift_stage.sv
// rtl/param_pipe_barrel_shifter_shift_stage.sv - one shift level (by 2**K) plus its pipeline register
// Sticky accumulation is present only with PARAM_PIPE_BARREL_SHIFTER_STICKY_EN.
module param_pipe_barrel_shifter_shift_stage
    import param_pipe_barrel_shifter_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int TAG_W   = 4,
    parameter  int K       = 0,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  shift_mode_e        in_mode,
    input  logic               in_fill,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef PARAM_PIPE_BARREL_SHIFTER_STICKY_EN
    input  logic               in_sticky,
    output logic               out_sticky,
`endif
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output shift_mode_e        out_mode,
    output logic               out_fill,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int S = 1 << K;

    logic [MAX_W-1:0] shift_wide;
    logic [WIDTH-1:0] level_data;
    logic             unused_wide;

    always_comb begin
        shift_wide = level_shift(MAX_W'(in_data), in_mode, in_fill, K, WIDTH);
        level_data = in_shamt[K] ? shift_wide[WIDTH-1:0] : in_data;
    end

    assign unused_wide = ^shift_wide;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_mode  <= SLL;
            out_fill  <= 1'b0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_data  <= level_data;
            out_shamt <= in_shamt;
            out_mode  <= in_mode;
            out_fill  <= in_fill;
            out_tag   <= in_tag;
        end
    end

`ifdef PARAM_PIPE_BARREL_SHIFTER_STICKY_EN
    logic lost;

    // Bits falling off the end of the word at this level; rotate never loses any.
    always_comb begin
        lost = 1'b0;
        case (in_mode)
            SRL, SRA: lost = |in_data[S-1:0];
            SLL:      lost = |in_data[WIDTH-1 -: S];
            default:  lost = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_sticky <= 1'b0;
        end else if (adv) begin
            out_sticky <= in_sticky | (in_shamt[K] & lost);
        end
    end
`endif

endmodule

// File: rtl/param_pipe_barrel_shifter.sv
// rtl/param_pipe_barrel_shifter.sv - pipelined multi-mode barrel shifter, one register per shift level
// Optional out_sticky via PARAM_PIPE_BARREL_SHIFTER_STICKY_EN.
module param_pipe_barrel_shifter
    import param_pipe_barrel_shifter_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int TAG_W   = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
`ifdef PARAM_PIPE_BARREL_SHIFTER_STICKY_EN
    ,
    output logic               out_sticky
`endif
);

    localparam int L = SHAMT_W;

    logic               adv;
    logic               pipe_valid [0:L];
    logic [WIDTH-1:0]   pipe_data  [0:L];
    logic [SHAMT_W-1:0] pipe_shamt [0:L];
    shift_mode_e        pipe_mode  [0:L];
    logic               pipe_fill  [0:L];
    logic [TAG_W-1:0]   pipe_tag   [0:L];
    logic               unused_tail;

    // The whole pipe moves together; it only stops when the output is held.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign pipe_valid[0] = in_valid;
    assign pipe_data[0]  = in_data;
    assign pipe_shamt[0] = in_shamt;
    assign pipe_mode[0]  = shift_mode_e'(in_mode);
    assign pipe_fill[0]  = in_data[WIDTH-1];
    assign pipe_tag[0]   = in_tag;

`ifdef PARAM_PIPE_BARREL_SHIFTER_STICKY_EN
    logic pipe_sticky [0:L];
    assign pipe_sticky[0] = 1'b0;
    assign out_sticky     = pipe_sticky[L];
`endif

    for (genvar k = 0; k < L; k++) begin : g_level
        param_pipe_barrel_shifter_shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .K     (k)
        ) u_shift_stage (
            .clk        (clk),
            .rst        (rst),
            .adv        (adv),
            .in_valid   (pipe_valid[k]),
            .in_data    (pipe_data[k]),
            .in_shamt   (pipe_shamt[k]),
            .in_mode    (pipe_mode[k]),
            .in_fill    (pipe_fill[k]),
            .in_tag     (pipe_tag[k]),
`ifdef PARAM_PIPE_BARREL_SHIFTER_STICKY_EN
            .in_sticky  (pipe_sticky[k]),
            .out_sticky (pipe_sticky[k+1]),
`endif
            .out_valid  (pipe_valid[k+1]),
            .out_data   (pipe_data[k+1]),
            .out_shamt  (pipe_shamt[k+1]),
            .out_mode   (pipe_mode[k+1]),
            .out_fill   (pipe_fill[k+1]),
            .out_tag    (pipe_tag[k+1])
        );
    end

    assign out_valid = pipe_valid[L];
    assign out_data  = pipe_data[L];
    assign out_tag   = pipe_tag[L];

    assign unused_tail = ^{pipe_shamt[L], pipe_mode[L], pipe_fill[L]};

endmodule

// File: doc/param_pipe_barrel_shifter.md
Name: param_pipe_barrel_shifter

Overview:
- Parametrised, pipelined, multi-mode barrel shifter. Next generation of the team's 8-bit left-only combinational shifter.
- Adds:
  - generic power-of-two width;
  - four shift modes, including rotate and arithmetic right;
  - one register per log2 shift level;
  - valid/ready flow control with a pass-through tag.
- Sits between an operand source (ALU issue / DSP normaliser) and its consumer. Accepts one operation per cycle when not stalled.

Parameters:
- WIDTH, 32, data width; power of two, >= 4.
- TAG_W, 4, width of the user tag carried alongside each operation.
- SHAMT_W, $clog2(WIDTH), derived localparam; never overridden. Also equals the number of levels L.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- in_tag  in  TAG_W  opaque tag, returned unmodified.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.
- out_sticky  out  1  only with the optional feature; otherwise absent.

Behaviour:
- Pipeline structure:
  - L = SHAMT_W levels. Level k shifts by 2^k when shamt[k]=1, else passes its input through.
  - Each level is followed by a register holding data, remaining shamt, mode, tag and valid.
- Global advance: adv = !out_valid | out_ready. All level registers load only when adv=1.
- in_ready = adv (combinational). A transfer occurs when in_valid & in_ready.
- Latency:
  - An operation accepted at edge N appears with out_valid=1 after edge N+L, provided no stall occurred.
  - Throughput is 1 per cycle.
  - Bubbles (valid=0) propagate like operations.
- Stall: out_valid & !out_ready freezes every level. out_data and out_tag hold stable until accepted.
- Fill rules per mode:
  - SLL fills 0s at the LSB.
  - SRL fills 0s at the MSB.
  - SRA fills copies of the original in_data[WIDTH-1], latched at level 0.
  - ROL wraps MSBs into the LSBs.
- shamt=0: out_data = in_data in every mode.
- Reset: every valid bit, out_valid, out_data, out_tag and out_sticky are 0. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight operations and produces no output.
- Unknown mode values cannot occur because the 2-bit field is fully decoded.

Optional Feature:
- Macro: PARAM_PIPE_BARREL_SHIFTER_STICKY_EN.
- Defined:
  - out_sticky port exists.
  - For SRL/SRA it is the OR of all bits shifted out past the LSB.
  - For SLL it is the OR of bits shifted out past the MSB.
  - For ROL it is 0.
  - Sticky is accumulated per level and pipelined with the data.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package param_pipe_barrel_shifter_pkg holds:
  - shift_mode_e enum: SLL=2'b00, SRL=2'b01, SRA=2'b10, ROL=2'b11;
  - a function computing the level-k combinational shift (data, mode, fill bit, k).
- One natural sub-module, shift_stage: one level's mux row plus its pipeline register. It is parametrised by WIDTH, TAG_W and level index K, and instantiated L times in a generate loop.

Test Plan (WIDTH=8, TAG_W=4, L=3):
- SLL: in_data=8'b1011_0001, shamt=3, tag=5 -> out_data=8'b1000_1000, out_tag=5, out_valid 3 cycles after acceptance.
- SRA: 8'h90, shamt=2 -> 8'hE4. SRL with the same operands -> 8'h24. Sticky build: SRL 8'h03 by 1 -> 8'h01, out_sticky=1.
- ROL: 8'h81 by 1 -> 8'h03; 8'hA5 by 4 -> 8'h5A; shamt=0 in each of the four modes returns the input unchanged.
- Back-to-back: 8 consecutive ops with out_ready=1 -> 8 results on consecutive cycles, in order, tags 0..7 matching.
- Backpressure: hold out_ready=0 for 4 cycles with the pipeline full -> in_ready=0, out_data/out_tag stable. On release the results drain in order, with no loss and no duplication.
- Reset: assert rst with 3 ops in flight -> the next cycle shows out_valid=0, out_data=0, in_ready=1, and no stale result ever emerges.
